// File: rtl/tt_sweep_checker_if.sv
// rtl/tt_sweep_checker_if.sv - gate stimulus/capture and result bundle for tt_sweep_checker
interface tt_sweep_checker_if;
   logic       start;
   logic       dut_out;
   logic       in1;
   logic       in2;
   logic       in3;
   logic       busy;
   logic       done;
   logic       pass;
   logic [7:0] table_q;
   logic [7:0] mismatch;

   modport master (
      output start,
      output dut_out,
      input  in1,
      input  in2,
      input  in3,
      input  busy,
      input  done,
      input  pass,
      input  table_q,
      input  mismatch
   );

   modport slave (
      input  start,
      input  dut_out,
      output in1,
      output in2,
      output in3,
      output busy,
      output done,
      output pass,
      output table_q,
      output mismatch
   );
endinterface

// File: rtl/tt_sweep_checker.sv
// rtl/tt_sweep_checker.sv - sweeps all 8 vectors through a 3-input gate and checks its truth table
module tt_sweep_checker #(
   parameter logic [7:0] EXPECTED = 8'hD5,
   parameter int         SETTLE   = 4
) (
   input logic             clk,
   input logic             rst,
   tt_sweep_checker_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

   state_t     state, state_d;
   logic [2:0] idx, idx_d;
   logic [7:0] cnt, cnt_d;
   logic [7:0] table_r, table_d;
   logic [7:0] mism_r, mism_d;
   logic       busy_r, busy_d;
   logic       done_r, done_d;
   logic       pass_r, pass_d;

   // Every output comes from a register, so dut_out never reaches an output combinationally.
   always_comb begin
      state_d = state;
      idx_d   = idx;
      cnt_d   = cnt;
      table_d = table_r;
      mism_d  = mism_r;
      busy_d  = busy_r;
      done_d  = 1'b0;
      pass_d  = pass_r;

      case (state)
         IDLE: begin
            if (bus.start) begin
               state_d = RUN;
               busy_d  = 1'b1;
               idx_d   = 3'd0;
               cnt_d   = 8'd0;
               table_d = 8'h00;
               mism_d  = 8'h00;
               pass_d  = 1'b0;
            end
         end
         RUN: begin
            if (cnt == SETTLE_LAST) begin
               cnt_d                  = 8'd0;
               table_d[3'd7 - idx]    = bus.dut_out;
               if (idx == 3'd7) begin
                  state_d = DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  idx_d   = 3'd0;
                  mism_d  = table_d ^ EXPECTED;
                  pass_d  = (table_d == EXPECTED);
               end else begin
                  idx_d = idx + 3'd1;
               end
            end else begin
               cnt_d = cnt + 8'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         idx     <= 3'd0;
         cnt     <= 8'd0;
         table_r <= 8'h00;
         mism_r  <= 8'h00;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         pass_r  <= 1'b0;
      end else begin
         state   <= state_d;
         idx     <= idx_d;
         cnt     <= cnt_d;
         table_r <= table_d;
         mism_r  <= mism_d;
         busy_r  <= busy_d;
         done_r  <= done_d;
         pass_r  <= pass_d;
      end
   end

   assign bus.in1      = idx[2];
   assign bus.in2      = idx[1];
   assign bus.in3      = idx[0];
   assign bus.busy     = busy_r;
   assign bus.done     = done_r;
   assign bus.pass     = pass_r;
   assign bus.table_q  = table_r;
   assign bus.mismatch = mism_r;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// tb/tb_tt_sweep_checker.sv - directed bench for tt_sweep_checker with SETTLE=4 and SETTLE=1 instances
module tb_tt_sweep_checker;
   localparam int SA = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   tt_sweep_checker_if bus_a();
   tt_sweep_checker_if bus_b();

   tt_sweep_checker #(.EXPECTED(8'hD5), .SETTLE(SA)) u_a (.clk(clk), .rst(rst), .bus(bus_a));
   tt_sweep_checker #(.EXPECTED(8'hD5), .SETTLE(1))  u_b (.clk(clk), .rst(rst), .bus(bus_b));

   logic [7:0] gate_code;
   logic [1:0] gate_mode;
   logic [2:0] vec_a, vec_b;

   assign vec_a = {bus_a.in1, bus_a.in2, bus_a.in3};
   assign vec_b = {bus_b.in1, bus_b.in2, bus_b.in3};

   // Gate models: 0 ideal, 1 stuck at 0, 2 inverted
   assign bus_a.dut_out = (gate_mode == 2'd1) ? 1'b0 :
                          (gate_mode == 2'd2) ? ~gate_code[3'd7 - vec_a] :
                                                 gate_code[3'd7 - vec_a];
   assign bus_b.dut_out = gate_code[3'd7 - vec_b];

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      string      name;
      logic [1:0] mode;
      bit         extra;
      logic [7:0] exp_tab;
      bit         exp_pass;
      logic [7:0] exp_mism;
   } vec_t;

   vec_t tbl[4];

   task automatic sweep_a(input bit extra, output int done_at, output int busy_cyc,
                          output int done_cnt, output int vec_err);
      logic [2:0] ev;
      done_at  = -1;
      busy_cyc = 0;
      done_cnt = 0;
      vec_err  = 0;
      @(negedge clk);
      bus_a.start = 1'b1;
      @(negedge clk);
      bus_a.start = 1'b0;
      for (int k = 0; k < 50; k++) begin
         ev = (bus_a.busy && k < 8 * SA) ? 3'(k / SA) : 3'd0;
         if (vec_a !== ev) vec_err++;
         if (bus_a.busy) busy_cyc++;
         if (bus_a.done) begin
            done_cnt++;
            if (done_at < 0) done_at = k;
         end
         bus_a.start = (extra && (k == 3 || k == 17 || k == 31 || k == 8 * SA)) ? 1'b1 : 1'b0;
         @(negedge clk);
      end
      bus_a.start = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int d_at, b_cyc, d_cnt, v_err, dn;
      logic [19:0] busy_tr, done_tr;
      int pass_cnt;
      logic [7:0] tab_b;
      int vb_err;

      tbl[0] = '{"ideal",    2'd0, 1'b0, 8'hD5, 1'b1, 8'h00};
      tbl[1] = '{"zero",     2'd1, 1'b0, 8'h00, 1'b0, 8'hD5};
      tbl[2] = '{"inverted", 2'd2, 1'b0, 8'h2A, 1'b0, 8'hFF};
      tbl[3] = '{"extra",    2'd0, 1'b1, 8'hD5, 1'b1, 8'h00};

      gate_code   = 8'hD5;
      gate_mode   = 2'd0;
      bus_a.start = 1'b0;
      bus_b.start = 1'b0;
      rst         = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_busy",     int'(bus_a.busy), 0);
      check("rst_done",     int'(bus_a.done), 0);
      check("rst_pass",     int'(bus_a.pass), 0);
      check("rst_table",    int'(bus_a.table_q), 'h00);
      check("rst_mismatch", int'(bus_a.mismatch), 'h00);
      check("rst_vec",      int'(vec_a), 0);
      check("rst_busy_b",   int'(bus_b.busy), 0);
      rst = 1'b0;

      for (int i = 0; i < 4; i++) begin
         gate_mode = tbl[i].mode;
         sweep_a(tbl[i].extra, d_at, b_cyc, d_cnt, v_err);
         check({tbl[i].name, "_done_at"},  d_at, 8 * SA);
         check({tbl[i].name, "_busy_cyc"}, b_cyc, 8 * SA);
         check({tbl[i].name, "_done_cnt"}, d_cnt, 1);
         check({tbl[i].name, "_vec_err"},  v_err, 0);
         check({tbl[i].name, "_table"},    int'(bus_a.table_q), int'(tbl[i].exp_tab));
         check({tbl[i].name, "_pass"},     int'(bus_a.pass), int'(tbl[i].exp_pass));
         check({tbl[i].name, "_mismatch"}, int'(bus_a.mismatch), int'(tbl[i].exp_mism));
      end

      // Abort a sweep while vector 3 is applied
      gate_mode = 2'd0;
      @(negedge clk);
      bus_a.start = 1'b1;
      @(negedge clk);
      bus_a.start = 1'b0;
      repeat (13) @(negedge clk);
      check("abort_pre_vec",   int'(vec_a), 3);
      check("abort_pre_table", int'(bus_a.table_q), 'hC0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy",     int'(bus_a.busy), 0);
      check("abort_done",     int'(bus_a.done), 0);
      check("abort_pass",     int'(bus_a.pass), 0);
      check("abort_table",    int'(bus_a.table_q), 'h00);
      check("abort_mismatch", int'(bus_a.mismatch), 'h00);
      check("abort_vec",      int'(vec_a), 0);
      dn = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (bus_a.done) dn++;
      end
      check("abort_no_done", dn, 0);
      sweep_a(1'b0, d_at, b_cyc, d_cnt, v_err);
      check("after_abort_done_at", d_at, 8 * SA);
      check("after_abort_table",   int'(bus_a.table_q), 'hD5);
      check("after_abort_pass",    int'(bus_a.pass), 1);

      // SETTLE=1 with start held high across two sweeps
      busy_tr  = '0;
      done_tr  = '0;
      pass_cnt = 0;
      tab_b    = 8'h00;
      vb_err   = 0;
      @(negedge clk);
      bus_b.start = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         busy_tr[k] = bus_b.busy;
         done_tr[k] = bus_b.done;
         if (k < 8 && vec_b !== 3'(k)) vb_err++;
         if ((k == 8 || k == 18) && bus_b.pass) pass_cnt++;
         if (k == 18) tab_b = bus_b.table_q;
      end
      bus_b.start = 1'b0;
      check("b2b_busy_trace", int'(busy_tr), 'h3FCFF);
      check("b2b_done_trace", int'(done_tr), 'h40100);
      check("b2b_vec_err",    vb_err, 0);
      check("b2b_pass_cnt",   pass_cnt, 2);
      check("b2b_table",      int'(tab_b), 'hD5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/tt_sweep_checker.md
TT_SWEEP_CHECKER -- requirements
Module: tt_sweep_checker

Purpose: sequencer placed directly upstream and downstream of a 3-input combinational logic gate. It drives all eight {in1,in2,in3} vectors into the gate, captures the gate output, assembles the 8-bit truth table and compares it against an expected hex code.

Interface
REQ-001 Parameters, one per line:
- EXPECTED, default 8'hD5, expected truth-table code.
- SETTLE, default 4, cycles each vector is held before its sample is taken; legal range 1..255.
REQ-002 Ports, one per line:
- clk input 1, single clock; all state changes on its rising edge.
- rst input 1, reset; synchronous, active-high.
- start input 1, request a sweep; sampled only in IDLE.
- dut_out input 1, output of the gate under test.
- in1 output 1, gate input, MSB of the vector.
- in2 output 1, gate input, middle bit.
- in3 output 1, gate input, LSB of the vector.
- busy output 1, sweep in progress.
- done output 1, one-cycle completion pulse.
- pass output 1, table_q == EXPECTED; valid from done onward.
- table_q output 8, captured truth table.
- mismatch output 8, table_q XOR EXPECTED.
REQ-003 The single clock is clk; reset is rst, synchronous and active-high.

Function
REQ-004 The FSM SHALL have states IDLE, RUN and DONE.
- IDLE -> RUN on start=1.
- RUN -> DONE after vector 7 is sampled.
- DONE -> IDLE unconditionally after one cycle.
REQ-005 Vector encoding: idx = {in1,in2,in3}. Vectors 0..7 SHALL be applied in ascending order, and in1..in3 SHALL be registered outputs.
REQ-006 Start timing: when IDLE samples start=1 at edge E0:
- from E0: busy=1, idx=0, the settle counter is cleared, and table_q and mismatch are cleared to 0;
- pass SHALL be cleared to 0 at E0.
REQ-007 Each vector SHALL be held for exactly SETTLE cycles.
- Vector i is sampled at edge E0+(i+1)*SETTLE; dut_out is captured into table_q[7-i].
- At the same edge idx advances to i+1, for i < 7.
REQ-008 Bit order: table_q[7] holds the result for idx=000 and table_q[0] holds the result for idx=111. With an ideal 0xD5 gate the pattern is 000->1, 001->1, 010->0, 011->1, 100->0, 101->1, 110->0, 111->1.
REQ-009 Completion at edge E0+8*SETTLE (capture of vector 7):
- state becomes DONE, busy=0, done=1;
- pass and mismatch are computed from the final table.
REQ-010 done SHALL be high for exactly one cycle (the DONE state).
REQ-011 pass, table_q and mismatch SHALL hold their values until the next accepted start or reset.
REQ-012 Busy duration: busy SHALL be high for exactly 8*SETTLE cycles per sweep.
REQ-013 Ignored start: start SHALL be ignored in RUN and DONE. With start held continuously high, a new sweep begins at the first IDLE edge, which is one cycle after done.
REQ-014 Inputs at rest: in1..in3 SHALL be 000 whenever busy=0.
REQ-015 Settle counter: the counter SHALL be 8 bits and wrap to 0 on each vector advance. SETTLE=1 SHALL sample on every edge with no idle gaps.
REQ-016 There SHALL be no combinational path from dut_out to any output.

Reset
REQ-017 While rst=1 at a clock edge:
- state=IDLE;
- in1=in2=in3=0;
- busy=0, done=0, pass=0;
- table_q=8'h00, mismatch=8'h00;
- counter=0.
REQ-018 Reset has priority over start and over every other condition.
REQ-019 rst asserted mid-sweep SHALL abort the sweep with no done pulse; partial results SHALL be discarded.
REQ-020 The first start after reset is released SHALL be accepted normally.

Verification
REQ-021 Ideal 0xD5 gate model, SETTLE=4, start pulsed at E0: the bench SHALL check
- done at E0+32;
- table_q=8'hD5, pass=1, mismatch=8'h00;
- busy high for 32 cycles.
REQ-022 dut_out tied to 0: table_q=8'h00, pass=0, mismatch=8'hD5.
REQ-023 Inverted gate model (~0xD5): table_q=8'h2A, pass=0, mismatch=8'hFF.
REQ-024 Extra start pulses during RUN and during DONE: no restart, exactly one done pulse, and the timing of REQ-021 is unchanged.
REQ-025 rst asserted while idx=3:
- the next cycle shows all outputs at their reset values and no done;
- a following start gives a full, correct sweep.
REQ-026 SETTLE=1 with start held high across two sweeps:
- busy for 8 cycles, then done for 1 cycle, then 1 IDLE cycle, then busy again;
- both sweeps report pass=1.
